// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage:
// ALU opcodes, multiplier FSM states and status bit positions.
package ex_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLL   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_PASSB = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1101;

   localparam int ST_Z = 2;
   localparam int ST_V = 1;
   localparam int ST_N = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } mul_state_e;

endpackage

// File: rtl/ex_alu.sv
// Single-cycle ALU used by the execute stage.
// Unknown opcodes (including OP_MUL) produce zero.
module ex_alu
   import ex_pkg::*;
#(
   parameter int DSIZE = 16
) (
   input  logic [3:0]       op,
   input  logic [DSIZE-1:0] a,
   input  logic [DSIZE-1:0] b,
   output logic [DSIZE-1:0] y,
   output logic [2:0]       status
);

   localparam int SW = $clog2(DSIZE);
   localparam int M  = DSIZE - 1;

   logic [SW-1:0] sh;
   logic          v;

   assign sh = b[SW-1:0];

   always_comb begin
      y = '0;
      v = 1'b0;
      case (op)
         OP_ADD: begin
            y = a + b;
            v = (a[M] == b[M]) && (y[M] != a[M]);
         end
         OP_SUB: begin
            y = a - b;
            v = (a[M] != b[M]) && (y[M] != a[M]);
         end
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_SLL:   y = a << sh;
         OP_SRL:   y = a >> sh;
         OP_SRA:   y = $signed(a) >>> sh;
         OP_SLT:   y = {{M{1'b0}}, $signed(a) < $signed(b)};
         OP_PASSB: y = b;
         default:  y = '0;
      endcase
   end

   assign status[ST_Z] = (y == '0);
   assign status[ST_V] = v;
   assign status[ST_N] = y[M];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding from MEM/WB and load-use detection.
// A MEM-stage load cannot forward; it raises load_use instead.
module fwd_hazard_unit #(
   parameter int DSIZE   = 16,
   parameter int RSIZE   = 4,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic             ex_valid,
   input  logic [RSIZE-1:0] rs1,
   input  logic [RSIZE-1:0] rs2,
   input  logic             sel_src1,
   input  logic             sel_src2,
   input  logic [DSIZE-1:0] rd1,
   input  logic [DSIZE-1:0] rd2,
   input  logic [RSIZE-1:0] mem_rd,
   input  logic             mem_rfwrite,
   input  logic             mem_mem2reg,
   input  logic [DSIZE-1:0] mem_result,
   input  logic [RSIZE-1:0] wb_rd,
   input  logic             wb_rfwrite,
   input  logic [DSIZE-1:0] wb_result,
   output logic [DSIZE-1:0] fwd1,
   output logic [DSIZE-1:0] fwd2,
   output logic             load_use
);

   logic ok1, ok2;
   logic hit_m1, hit_m2;
   logic use_m1, use_m2;
   logic use_w1, use_w2;

   assign ok1 = !(R0_ZERO && rs1 == '0);
   assign ok2 = !(R0_ZERO && rs2 == '0);

   assign hit_m1 = ok1 && mem_rfwrite && mem_rd == rs1;
   assign hit_m2 = ok2 && mem_rfwrite && mem_rd == rs2;

   assign use_m1 = hit_m1 && !mem_mem2reg;
   assign use_m2 = hit_m2 && !mem_mem2reg;
   assign use_w1 = !use_m1 && ok1 && wb_rfwrite && wb_rd == rs1;
   assign use_w2 = !use_m2 && ok2 && wb_rfwrite && wb_rd == rs2;

   always_comb begin
      fwd1 = rd1;
      unique case (1'b1)
         use_m1:  fwd1 = mem_result;
         use_w1:  fwd1 = wb_result;
         default: fwd1 = rd1;
      endcase
   end

   always_comb begin
      fwd2 = rd2;
      unique case (1'b1)
         use_m2:  fwd2 = mem_result;
         use_w2:  fwd2 = wb_result;
         default: fwd2 = rd2;
      endcase
   end

   assign load_use = ex_valid && mem_mem2reg &&
                     ((sel_src1 && hit_m1) ||
                      (sel_src2 && hit_m2));

endmodule

// File: rtl/ex_stage_fwd_mc.sv
// Execute stage with forwarding, load-use stall and iterative multiplier.
// MEM-stage forwarding control enters on mem_fwd_* to keep it apart from the EX/MEM outputs.
module ex_stage_fwd_mc
   import ex_pkg::*;
#(
   parameter int DSIZE   = 16,
   parameter int RSIZE   = 4,
   parameter bit R0_ZERO = 1'b1,
   parameter bit MUL_EN  = 1'b1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             flush,
   input  logic             ex_valid,
   input  logic [DSIZE-1:0] ex_pc1,
   input  logic [DSIZE-1:0] ex_rd1,
   input  logic [DSIZE-1:0] ex_rd2,
   input  logic [DSIZE-1:0] ex_imm,
   input  logic [RSIZE-1:0] ex_rs1,
   input  logic [RSIZE-1:0] ex_rs2,
   input  logic [RSIZE-1:0] ex_rd,
   input  logic [3:0]       ex_aluop,
   input  logic             ex_sel_src1,
   input  logic             ex_sel_src2,
   input  logic             ex_mem2reg,
   input  logic             ex_rfwrite,
   input  logic             ex_sel_alu_pc1,
   input  logic             ex_memwrite,
   input  logic             ex_memenab,
   input  logic [RSIZE-1:0] mem_rd,
   input  logic [RSIZE-1:0] wb_rd,
   input  logic             mem_fwd_rfwrite,
   input  logic             mem_fwd_mem2reg,
   input  logic             wb_rfwrite,
   input  logic [DSIZE-1:0] mem_result,
   input  logic [DSIZE-1:0] wb_result,
   output logic             stall,
   output logic             mem_valid,
   output logic             mem_mem2reg,
   output logic             mem_rfwrite,
   output logic             mem_sel_alu_pc1,
   output logic [DSIZE-1:0] mem_aluresult,
   output logic [DSIZE-1:0] mem_pc1,
   output logic [RSIZE-1:0] mem_rdest,
   output logic [2:0]       alu_status,
   output logic [DSIZE-1:0] ram_addr,
   output logic [DSIZE-1:0] ram_wdata,
   output logic             ram_we,
   output logic             ram_en
);

   localparam int CW = $clog2(DSIZE);

   logic [DSIZE-1:0]   fwd1, fwd2;
   logic [DSIZE-1:0]   op1, op2;
   logic [DSIZE-1:0]   alu_y;
   logic [2:0]         alu_st;
   logic               load_use;
   logic               is_mul;
   mul_state_e         state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*DSIZE-1:0] acc, mcand;
   logic [DSIZE-1:0]   mplier;
   logic               mul_start, stall_i;
   logic               wr, wr_mul;
   logic [DSIZE-1:0]   prod_lo, prod_hi;
   logic [DSIZE-1:0]   res;
   logic [2:0]         res_st;

   fwd_hazard_unit #(
      .DSIZE   (DSIZE),
      .RSIZE   (RSIZE),
      .R0_ZERO (R0_ZERO)
   ) u_fwd (
      .ex_valid    (ex_valid),
      .rs1         (ex_rs1),
      .rs2         (ex_rs2),
      .sel_src1    (ex_sel_src1),
      .sel_src2    (ex_sel_src2),
      .rd1         (ex_rd1),
      .rd2         (ex_rd2),
      .mem_rd      (mem_rd),
      .mem_rfwrite (mem_fwd_rfwrite),
      .mem_mem2reg (mem_fwd_mem2reg),
      .mem_result  (mem_result),
      .wb_rd       (wb_rd),
      .wb_rfwrite  (wb_rfwrite),
      .wb_result   (wb_result),
      .fwd1        (fwd1),
      .fwd2        (fwd2),
      .load_use    (load_use)
   );

   assign op1 = ex_sel_src1 ? fwd1 : ex_imm;
   assign op2 = ex_sel_src2 ? fwd2 : ex_imm;

   ex_alu #(.DSIZE(DSIZE)) u_alu (
      .op     (ex_aluop),
      .a      (op1),
      .b      (op2),
      .y      (alu_y),
      .status (alu_st)
   );

   assign is_mul = MUL_EN && (ex_aluop == OP_MUL);

   always_comb begin
      state_nx  = state;
      stall_i   = 1'b0;
      mul_start = 1'b0;
      wr        = 1'b0;
      wr_mul    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (ex_valid && !load_use && is_mul) begin
               mul_start = 1'b1;
               stall_i   = 1'b1;
               state_nx  = S_BUSY;
            end else begin
               stall_i = load_use;
               wr      = ex_valid && !load_use;
            end
         end
         S_BUSY: begin
            stall_i = 1'b1;
            if (cnt == CW'(1))
               state_nx = S_DONE;
         end
         S_DONE: begin
            wr       = ex_valid;
            wr_mul   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (flush) begin
         state_nx  = S_IDLE;
         stall_i   = 1'b0;
         mul_start = 1'b0;
         wr        = 1'b0;
      end
   end

   // First shift-add step happens in the start cycle
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         state <= state_nx;
         if (mul_start) begin
            acc    <= op2[0] ? {{DSIZE{1'b0}}, op1} : '0;
            mcand  <= {{(DSIZE-1){1'b0}}, op1, 1'b0};
            mplier <= op2 >> 1;
            cnt    <= CW'(DSIZE-1);
         end else if (state == S_BUSY) begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
         end
      end
   end

   assign prod_lo = acc[DSIZE-1:0];
   assign prod_hi = acc[2*DSIZE-1:DSIZE];

   always_comb begin
      res    = alu_y;
      res_st = alu_st;
      if (wr_mul) begin
         res          = prod_lo;
         res_st[ST_Z] = (prod_lo == '0);
         res_st[ST_V] = (prod_hi != '0);
         res_st[ST_N] = prod_lo[DSIZE-1];
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         mem_valid       <= 1'b0;
         mem_mem2reg     <= 1'b0;
         mem_rfwrite     <= 1'b0;
         mem_sel_alu_pc1 <= 1'b0;
         mem_aluresult   <= '0;
         mem_pc1         <= '0;
         mem_rdest       <= '0;
         alu_status      <= '0;
      end else if (wr) begin
         mem_valid       <= 1'b1;
         mem_mem2reg     <= ex_mem2reg;
         mem_rfwrite     <= ex_rfwrite;
         mem_sel_alu_pc1 <= ex_sel_alu_pc1;
         mem_aluresult   <= res;
         mem_pc1         <= ex_pc1;
         mem_rdest       <= ex_rd;
         alu_status      <= res_st;
      end else begin
         mem_valid       <= 1'b0;
         mem_mem2reg     <= 1'b0;
         mem_rfwrite     <= 1'b0;
         mem_sel_alu_pc1 <= 1'b0;
      end
   end

   assign stall     = stall_i && !Rst;
   assign ram_addr  = alu_y;
   assign ram_wdata = fwd2;
   assign ram_en    = ex_valid && !stall && !flush && ex_memenab;
   assign ram_we    = ex_valid && !stall && !flush && ex_memwrite;

endmodule
